// File: rtl/wb_writeback_unit.sv
// Writeback stage: picks load data or the ALU result, extracts and extends sub-word loads,
// and splits wide results into lo/hi writes. Optional retired-write counter: WB_COUNT_EN.
module wb_writeback_unit #(
   parameter int DATA_W       = 32,
   parameter int ADDR_W       = 5,
   parameter bit R0_HARDWIRED = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [3:0]          wb_in,
   input  logic [DATA_W-1:0]   mem_data_in,
   input  logic [2*DATA_W-1:0] alu_res_in,
   input  logic [ADDR_W-1:0]   dest_in,
   input  logic [1:0]          float_in,
   input  logic                alu_mem_read_in,
   input  logic                alu_RegWrite_in,
   output logic                rf_we,
   output logic                fp_we,
   output logic [ADDR_W-1:0]   wr_addr,
   output logic [DATA_W-1:0]   wr_data,
   output logic                wide_err,
   output logic [31:0]         wb_count
);

   typedef enum logic {IDLE, WR_HI} state_t;

   state_t              r_state;
   logic                r_rf_we, r_fp_we, r_wide_err;
   logic [ADDR_W-1:0]   r_wr_addr, r_hi_addr;
   logic [DATA_W-1:0]   r_wr_data, r_hi_data;
   logic                r_hi_rf, r_hi_fp, r_hi_err;

   logic [1:0]          w_off;
   logic [7:0]          w_byte;
   logic [DATA_W/2-1:0] w_half;
   logic [DATA_W-1:0]   w_load_data;
   logic                w_accept, w_int_tgt, w_fp_tgt, w_r0, w_wide, w_last;

   assign w_off     = alu_res_in[1:0];
   assign w_byte    = mem_data_in[8*w_off +: 8];
   assign w_half    = w_off[1] ? mem_data_in[DATA_W-1:DATA_W/2] : mem_data_in[DATA_W/2-1:0];
   assign w_accept  = in_valid && (r_state == IDLE);
   assign w_int_tgt = alu_RegWrite_in && (float_in == 2'b00);
   assign w_fp_tgt  = alu_RegWrite_in && (float_in == 2'b01);
   assign w_r0      = R0_HARDWIRED && (dest_in == '0);
   assign w_wide    = wb_in[3] && !alu_mem_read_in;
   assign w_last    = (dest_in == '1);

   // wb_in[2] selects zero extension; otherwise the sub-word sign bit is replicated
   always_comb begin
      w_load_data = mem_data_in;
      case (wb_in[1:0])
         2'b01:   w_load_data = {{(DATA_W/2){w_half[DATA_W/2-1] & ~wb_in[2]}}, w_half};
         2'b10:   w_load_data = {{(DATA_W-8){w_byte[7] & ~wb_in[2]}}, w_byte};
         default: w_load_data = mem_data_in;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_rf_we    <= 1'b0;
         r_fp_we    <= 1'b0;
         r_wide_err <= 1'b0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
         r_hi_addr  <= '0;
         r_hi_data  <= '0;
         r_hi_rf    <= 1'b0;
         r_hi_fp    <= 1'b0;
         r_hi_err   <= 1'b0;
      end else begin
         r_rf_we    <= 1'b0;
         r_fp_we    <= 1'b0;
         r_wide_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_rf_we   <= w_int_tgt && !w_r0;
                  r_fp_we   <= w_fp_tgt;
                  r_wr_addr <= dest_in;
                  r_wr_data <= alu_mem_read_in ? w_load_data : alu_res_in[DATA_W-1:0];
                  if (w_wide) begin
                     // unqualified wide ops still take the hi cycle so timing never varies
                     r_state   <= WR_HI;
                     r_hi_data <= alu_res_in[2*DATA_W-1:DATA_W];
                     r_hi_addr <= dest_in + ADDR_W'(1);
                     r_hi_rf   <= w_int_tgt && !w_last;
                     r_hi_fp   <= w_fp_tgt && !w_last;
                     r_hi_err  <= (w_int_tgt || w_fp_tgt) && w_last;
                  end
               end
            end
            WR_HI: begin
               r_rf_we    <= r_hi_rf;
               r_fp_we    <= r_hi_fp;
               r_wide_err <= r_hi_err;
               r_wr_addr  <= r_hi_addr;
               r_wr_data  <= r_hi_data;
               r_state    <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign in_ready = (r_state == IDLE);
   assign rf_we    = r_rf_we;
   assign fp_we    = r_fp_we;
   assign wr_addr  = r_wr_addr;
   assign wr_data  = r_wr_data;
   assign wide_err = r_wide_err;

`ifdef WB_COUNT_EN
   logic [31:0] r_count;

   always_ff @(posedge clk) begin
      if (rst)
         r_count <= '0;
      else if (r_rf_we || r_fp_we)
         r_count <= r_count + 32'd1;
   end

   assign wb_count = r_count;
`else
   assign wb_count = '0;
`endif

endmodule

// File: tb/tb_wb_writeback_unit.sv
// Bench for wb_writeback_unit: directed cases then randomized traffic checked against
// a queue of expected per-cycle writes built from the writeback rules.
module tb_wb_writeback_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  wb_in;
   logic [31:0] mem_data_in;
   logic [63:0] alu_res_in;
   logic [4:0]  dest_in;
   logic [1:0]  float_in;
   logic        alu_mem_read_in;
   logic        alu_RegWrite_in;
   logic        rf_we, fp_we;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        wide_err;
   logic [31:0] wb_count;

   wb_writeback_unit dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .wb_in(wb_in),
      .mem_data_in(mem_data_in), .alu_res_in(alu_res_in), .dest_in(dest_in),
      .float_in(float_in), .alu_mem_read_in(alu_mem_read_in),
      .alu_RegWrite_in(alu_RegWrite_in), .rf_we(rf_we), .fp_we(fp_we),
      .wr_addr(wr_addr), .wr_data(wr_data), .wide_err(wide_err), .wb_count(wb_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          rf;
      bit          fp;
      bit          err;
      logic [4:0]  addr;
      logic [31:0] data;
   } wr_t;

   wr_t   q[$];
   int    n_total = 0;
   int    n_pass  = 0;
   int    n_fail  = 0;
   int    exp_cnt = 0;
   bit    last_acc = 1'b0;

   task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] load_val(logic [31:0] mem, logic [1:0] off,
                                            logic [1:0] sz, bit uns);
      logic [31:0] raw;
      int          bits;
      if (sz == 2'd1) begin
         raw  = (off >= 2'd2) ? mem / 32'd65536 : mem % 32'd65536;
         bits = 16;
      end else if (sz == 2'd2) begin
         raw  = (mem / (32'd1 << (8 * int'(off)))) % 32'd256;
         bits = 8;
      end else begin
         return mem;
      end
      if (!uns && raw >= (32'd1 << (bits - 1)))
         raw = raw - (32'd1 << bits);
      return raw;
   endfunction

   task automatic set_in(bit v, logic [3:0] wb, logic [31:0] mem, logic [63:0] alu,
                         logic [4:0] dest, logic [1:0] fl, bit mr, bit rw);
      in_valid = v; wb_in = wb; mem_data_in = mem; alu_res_in = alu;
      dest_in = dest; float_in = fl; alu_mem_read_in = mr; alu_RegWrite_in = rw;
   endtask

   // One clock: predict from current inputs, advance, compare outputs with the queue head.
   task automatic cycle();
      wr_t lo, hi, cur;
      bit  ready_exp, is_int, is_fp;
      ready_exp = (q.size() == 0);
      check("in_ready", {63'd0, in_ready}, {63'd0, ready_exp});
      last_acc = in_valid && ready_exp;
      if (last_acc) begin
         is_int  = alu_RegWrite_in && float_in == 2'b00;
         is_fp   = alu_RegWrite_in && float_in == 2'b01;
         lo.rf   = is_int && dest_in != 5'd0;
         lo.fp   = is_fp;
         lo.err  = 1'b0;
         lo.addr = dest_in;
         lo.data = alu_mem_read_in ? load_val(mem_data_in, alu_res_in[1:0], wb_in[1:0], wb_in[2])
                                   : alu_res_in[31:0];
         q.push_back(lo);
         if (wb_in[3] && !alu_mem_read_in) begin
            hi.rf   = is_int && dest_in != 5'd31;
            hi.fp   = is_fp && dest_in != 5'd31;
            hi.err  = (is_int || is_fp) && dest_in == 5'd31;
            hi.addr = dest_in + 5'd1;
            hi.data = alu_res_in[63:32];
            q.push_back(hi);
         end
      end
      @(posedge clk);
      #1;
      cur = '{rf: 1'b0, fp: 1'b0, err: 1'b0, addr: 5'd0, data: 32'd0};
      if (q.size() != 0) cur = q.pop_front();
      check("rf_we", {63'd0, rf_we}, {63'd0, cur.rf});
      check("fp_we", {63'd0, fp_we}, {63'd0, cur.fp});
      check("wide_err", {63'd0, wide_err}, {63'd0, cur.err});
`ifdef WB_COUNT_EN
      check("wb_count", {32'd0, wb_count}, 64'(exp_cnt));
`else
      check("wb_count", {32'd0, wb_count}, 64'd0);
`endif
      if (cur.rf || cur.fp) begin
         check("wr_addr", {59'd0, wr_addr}, {59'd0, cur.addr});
         check("wr_data", {32'd0, wr_data}, {32'd0, cur.data});
         exp_cnt++;
      end
   endtask

   task automatic check_reset_state();
      check("rst_rf_we", {63'd0, rf_we}, 64'd0);
      check("rst_fp_we", {63'd0, fp_we}, 64'd0);
      check("rst_wr_addr", {59'd0, wr_addr}, 64'd0);
      check("rst_wr_data", {32'd0, wr_data}, 64'd0);
      check("rst_wide_err", {63'd0, wide_err}, 64'd0);
      check("rst_wb_count", {32'd0, wb_count}, 64'd0);
      check("rst_in_ready", {63'd0, in_ready}, 64'd1);
   endtask

   initial begin
      rst = 1'b1;
      set_in(0, 4'd0, 32'd0, 64'd0, 5'd0, 2'b00, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check_reset_state();

      // ALU write, then an idle cycle where the bus must hold
      set_in(1, 4'b0000, 32'd0, 64'h0000_0000_1234_5678, 5'd5, 2'b00, 0, 1);
      cycle();
      set_in(0, 4'd0, 32'd0, 64'd0, 5'd0, 2'b00, 0, 0);
      cycle();
      check("hold_addr", {59'd0, wr_addr}, 64'd5);
      check("hold_data", {32'd0, wr_data}, 64'h1234_5678);

      // Signed and unsigned byte loads at offset 3
      set_in(1, 4'b0010, 32'h80FF_7F01, 64'd3, 5'd6, 2'b00, 1, 1);
      cycle();
      check("sbyte", {32'd0, wr_data}, 64'hFFFF_FF80);
      set_in(1, 4'b0110, 32'h80FF_7F01, 64'd3, 5'd6, 2'b00, 1, 1);
      cycle();
      check("ubyte", {32'd0, wr_data}, 64'h0000_0080);

      // Wide op with the next entry stalled behind it
      set_in(1, 4'b1000, 32'd0, 64'hAAAA_BBBB_CCCC_DDDD, 5'd8, 2'b00, 0, 1);
      cycle();
      check("wide_lo", {32'd0, wr_data}, 64'hCCCC_DDDD);
      set_in(1, 4'b0000, 32'd0, 64'h55, 5'd3, 2'b00, 0, 1);
      cycle();
      check("wide_hi_addr", {59'd0, wr_addr}, 64'd9);
      check("wide_hi_data", {32'd0, wr_data}, 64'hAAAA_BBBB);
      cycle();
      set_in(0, 4'd0, 32'd0, 64'd0, 5'd0, 2'b00, 0, 0);
      cycle();

      // Wide to r31: lo written, hi dropped with a one-cycle error pulse
      set_in(1, 4'b1000, 32'd0, 64'h1111_2222_3333_4444, 5'd31, 2'b00, 0, 1);
      cycle();
      set_in(0, 4'd0, 32'd0, 64'd0, 5'd0, 2'b00, 0, 0);
      cycle();
      check("r31_err", {63'd0, wide_err}, 64'd1);
      cycle();

      // r0 integer write suppressed; FP r0 write allowed
      set_in(1, 4'b0000, 32'd0, 64'h77, 5'd0, 2'b00, 0, 1);
      cycle();
      check("r0_int", {63'd0, rf_we}, 64'd0);
      set_in(1, 4'b0000, 32'd0, 64'h99, 5'd0, 2'b01, 0, 1);
      cycle();
      check("r0_fp", {63'd0, fp_we}, 64'd1);

      // Unqualified wide op still occupies the hi cycle
      set_in(1, 4'b1000, 32'd0, 64'h1, 5'd4, 2'b00, 0, 0);
      cycle();
      set_in(0, 4'd0, 32'd0, 64'd0, 5'd0, 2'b00, 0, 0);
      cycle();
      cycle();

      // Reset during the hi cycle drops the pending write
      set_in(1, 4'b1000, 32'd0, 64'hDEAD_BEEF_0000_0001, 5'd10, 2'b00, 0, 1);
      cycle();
      set_in(0, 4'd0, 32'd0, 64'd0, 5'd0, 2'b00, 0, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      q.delete();
      exp_cnt = 0;
      check_reset_state();

      // Three qualified writes plus one suppressed r0 write
      set_in(1, 4'b0000, 32'd0, 64'h1, 5'd1, 2'b00, 0, 1);
      cycle();
      set_in(1, 4'b0000, 32'd0, 64'h2, 5'd0, 2'b00, 0, 1);
      cycle();
      set_in(1, 4'b0000, 32'd0, 64'h3, 5'd2, 2'b01, 0, 1);
      cycle();
      set_in(1, 4'b0000, 32'd0, 64'h4, 5'd3, 2'b00, 0, 1);
      cycle();
      set_in(0, 4'd0, 32'd0, 64'd0, 5'd0, 2'b00, 0, 0);
      cycle();
      cycle();
`ifdef WB_COUNT_EN
      check("count3", {32'd0, wb_count}, 64'd3);
`else
      check("count_off", {32'd0, wb_count}, 64'd0);
`endif

      // Randomized traffic; a stalled entry is held until accepted
      last_acc = 1'b1;
      for (int i = 0; i < 500; i++) begin
         if (!in_valid || last_acc) begin
            logic [4:0] d;
            d = 5'($urandom);
            if ($urandom_range(0, 7) == 0) d = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'd31;
            set_in($urandom_range(0, 3) != 0, 4'($urandom), $urandom, {$urandom, $urandom},
                   d, 2'($urandom), 1'($urandom), $urandom_range(0, 3) != 0);
         end
         cycle();
      end
      set_in(0, 4'd0, 32'd0, 64'd0, 5'd0, 2'b00, 0, 0);
      repeat (3) cycle();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/wb_writeback_unit.md
Name: wb_writeback_unit

Overview:
Writeback stage; consumes the MEM/WB pipeline register outputs and drives the integer and FP register file write ports. Selects load data vs ALU result, performs load sub-word extract/extend, and splits 64-bit results into two sequential 32-bit writes to dest and dest+1. The registered write bus doubles as the WB forwarding source for the EX-stage bypass logic.

Parameters:
DATA_W, 32, register file data width
ADDR_W, 5, register address width
R0_HARDWIRED, 1, 1 = integer writes to r0 are suppressed

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  MEM/WB entry valid
in_ready  output  1  unit can accept an entry this cycle
wb_in  input  4  [1:0] load size (00 word, 01 half, 10 byte, 11 word), [2] load unsigned, [3] wide 64-bit write
mem_data_in  input  32  load data
alu_res_in  input  64  ALU result; [1:0] also gives the load byte offset
dest_in  input  5  destination register
float_in  input  2  00 int RF, 01 FP RF, 1x no write
alu_mem_read_in  input  1  1 = write load data, 0 = write ALU result
alu_RegWrite_in  input  1  write enable
rf_we  output  1  integer RF write enable
fp_we  output  1  FP RF write enable
wr_addr  output  5  write address, shared by both RFs
wr_data  output  32  write data, shared by both RFs
wide_err  output  1  one-cycle pulse: wide write to register 31, hi half dropped
wb_count  output  32  retired-write counter (see Optional Feature)

Behaviour:
- Reset: rf_we=0, fp_we=0, wr_addr=0, wr_data=0, wide_err=0, wb_count=0, state=IDLE, in_ready=1 in the cycle after reset.
- Accept occurs on a rising edge with in_valid && in_ready. All write outputs are registered: 1-cycle latency from accept to rf_we/fp_we.
- States:
  - IDLE: in_ready=1.
  - WR_HI: in_ready=0; the hi half is held in an internal register.
- Write qualification: the write happens only if alu_RegWrite_in=1 and float_in[1]=0. float_in=00 targets rf_we; float_in=01 targets fp_we.
- If R0_HARDWIRED and the integer target has dest=0: rf_we=0 (the hi write of a wide op to r1 still occurs).
- Data select:
  - alu_mem_read_in=1: extract from mem_data_in using off=alu_res_in[1:0].
    - Byte: mem_data_in[8*off+:8].
    - Half: off[1] selects the upper/lower 16 bits; off[0] is ignored.
    - Sub-word results are sign-extended, or zero-extended when wb_in[2]=1.
  - alu_mem_read_in=0: alu_res_in[31:0].
- Wide op (wb_in[3]=1, alu_mem_read_in=0):
  - Cycle after accept: write lo = alu_res_in[31:0] to dest_in; state -> WR_HI.
  - Next cycle: write hi = alu_res_in[63:32] to dest_in+1; state -> IDLE.
- wb_in[3] with alu_mem_read_in=1: wide is ignored and the op is treated as a normal load.
- Wide op with dest_in=31: lo is written, the hi write is suppressed, wide_err pulses in the hi cycle, and WR_HI is still traversed (timing stays uniform).
- Unqualified wide op (no write): still traverses WR_HI, with no enables asserted.
- Cycles with no accept and not in WR_HI: rf_we=fp_we=0; wr_addr/wr_data hold their last values.
- in_valid while in_ready=0: ignored. The upstream must hold the entry (stall).
- Reset in WR_HI: the pending hi write is dropped and all outputs clear next cycle.

Optional Feature:
WB_COUNT_EN
- Defined: wb_count increments by 1 on every cycle in which rf_we or fp_we is asserted. It wraps 0xFFFFFFFF -> 0 and is cleared by rst.
- Undefined: wb_count is tied to 0 and no counter logic is synthesized.

Test Plan:
- ALU write: accept alu_res=0x1234_5678, dest=5, float=00, RegWrite=1 -> next cycle rf_we=1, wr_addr=5, wr_data=0x12345678, fp_we=0.
- Signed byte load: mem_data=0x80FF_7F01, off=3, wb_in=4'b0010 -> wr_data=0xFFFFFF80; same with wb_in[2]=1 -> 0x00000080.
- Wide op: alu_res=0xAAAA_BBBB_CCCC_DDDD, dest=8, back-to-back in_valid -> cycle1 write r8=0xCCCCDDDD, cycle2 write r9=0xAAAABBBB with in_ready=0, next entry accepted in the cycle after.
- Boundaries:
  - Wide with dest=31 -> r31=lo, no hi write, wide_err=1 for exactly one cycle.
  - Int write to dest=0 -> rf_we=0.
  - float_in=01, dest=0 -> fp_we=1.
- Reset asserted during WR_HI -> no hi write, all outputs 0, in_ready=1 after.
- With WB_COUNT_EN defined: 3 qualified writes + 1 suppressed r0 write -> wb_count=3; without the macro -> 0.
